// File: rtl/ddram_dl_bridge.sv
// Download-to-DDR byte-port bridge: buffers HPS ioctl bytes in a small FIFO, replays them as
// edge-triggered writes, and arbitrates a single-byte core read port behind the writes.
module ddram_dl_bridge #(
    parameter int unsigned FIFO_AW   = 3,
    parameter logic [27:0] BASE_ADDR = 28'h0
) (
    input  logic        DDRAM_CLK,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        rd_req,
    input  logic [24:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        load_done,
    output logic [24:0] load_size,
    output logic        overflow,
    output logic [27:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] WAIT_LVL = (FIFO_AW+1)'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, STROBE, ACKWAIT} state_t;
    state_t state, state_nx;

    logic [24:0]        fifo_addr [DEPTH];
    logic [7:0]         fifo_data [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_nx;
    logic               fifo_full, fifo_empty, push, pop;
    logic               issue_wr, issue_rd, rd_done, op_rd;
    logic [24:0]        rd_addr_q;
    logic               dl_q, dl_rise, armed;
    logic [24:0]        size_base, addr_p1;

    assign fifo_full  = (count == FULL_LVL);
    assign fifo_empty = (count == '0);
    assign push       = ioctl_wr && !fifo_full;
    assign dl_rise    = ioctl_download && !dl_q;
    assign addr_p1    = ioctl_addr + 25'd1;
    assign size_base  = dl_rise ? '0 : load_size;

    // Strobes are decoded from state so a reset drops them on the very next cycle
    assign mem_we = (state == STROBE) && !op_rd;
    assign mem_rd = (state == STROBE) && op_rd;

    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        pop      = 1'b0;
        rd_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    issue_wr = 1'b1;
                    state_nx = STROBE;
                end else if (rd_busy) begin
                    issue_rd = 1'b1;
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                if (!mem_ready) state_nx = ACKWAIT;
            end
            ACKWAIT: begin
                if (mem_ready) begin
                    state_nx = IDLE;
                    if (op_rd) rd_done = 1'b1;
                    else       pop     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr;
            fifo_data[wr_ptr] <= ioctl_dout;
        end
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
            op_rd      <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            rd_busy    <= 1'b0;
            rd_addr_q  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            dl_q       <= 1'b0;
            armed      <= 1'b0;
            load_done  <= 1'b0;
            load_size  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nx;
            ioctl_wait <= (count_nx >= WAIT_LVL);

            if (issue_wr) begin
                op_rd    <= 1'b0;
                mem_addr <= BASE_ADDR + {3'b0, fifo_addr[rd_ptr]};
                mem_din  <= fifo_data[rd_ptr];
            end else if (issue_rd) begin
                op_rd    <= 1'b1;
                mem_addr <= BASE_ADDR + {3'b0, rd_addr_q};
            end

            // rd_busy covers both the pending and the in-flight read
            rd_valid <= rd_done;
            if (rd_done) begin
                rd_data <= mem_dout;
                rd_busy <= 1'b0;
            end else if (rd_req && !rd_busy) begin
                rd_busy   <= 1'b1;
                rd_addr_q <= rd_addr;
            end

            dl_q <= ioctl_download;
            if (dl_rise) begin
                load_done <= 1'b0;
                armed     <= 1'b1;
            end else if (armed && !ioctl_download && fifo_empty && state == IDLE) begin
                load_done <= 1'b1;
                armed     <= 1'b0;
            end

            if (push && addr_p1 > size_base) load_size <= addr_p1;
            else                             load_size <= size_base;
            overflow <= (overflow && !dl_rise) || (ioctl_wr && fifo_full);
        end
    end
endmodule

// File: tb/tb_ddram_dl_bridge.sv
// Bench for ddram_dl_bridge: transaction-level model (expected-write queue, occupancy, read
// tracking) plus a byte-port model with configurable busy time, and directed scenarios.
module tb_ddram_dl_bridge;
    localparam logic [27:0] BASE_A = 28'h0;
    localparam logic [27:0] BASE_B = 28'hFFFFFFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0, ioctl_download = 1'b0, ioctl_wr = 1'b0, rd_req = 1'b0;
    logic [24:0] ioctl_addr = '0, rd_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        mem_ready = 1'b1;
    logic [7:0]  mem_dout = '0;

    logic        a_wait, a_rd_busy, a_rd_valid, a_load_done, a_overflow, a_mem_we, a_mem_rd;
    logic [7:0]  a_rd_data, a_mem_din;
    logic [24:0] a_load_size;
    logic [27:0] a_mem_addr;
    logic        b_wait, b_rd_busy, b_rd_valid, b_load_done, b_overflow, b_mem_we, b_mem_rd;
    logic [7:0]  b_rd_data, b_mem_din;
    logic [24:0] b_load_size;
    logic [27:0] b_mem_addr;

    ddram_dl_bridge #(.FIFO_AW(3), .BASE_ADDR(BASE_A)) dut (
        .DDRAM_CLK(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(a_wait), .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(a_rd_busy),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .load_done(a_load_done),
        .load_size(a_load_size), .overflow(a_overflow), .mem_addr(a_mem_addr),
        .mem_din(a_mem_din), .mem_we(a_mem_we), .mem_rd(a_mem_rd), .mem_dout(mem_dout),
        .mem_ready(mem_ready));

    // Same stimulus and port timing, offset base: only the address differs
    ddram_dl_bridge #(.FIFO_AW(3), .BASE_ADDR(BASE_B)) dut_b (
        .DDRAM_CLK(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(b_wait), .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(b_rd_busy),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .load_done(b_load_done),
        .load_size(b_load_size), .overflow(b_overflow), .mem_addr(b_mem_addr),
        .mem_din(b_mem_din), .mem_we(b_mem_we), .mem_rd(b_mem_rd), .mem_dout(mem_dout),
        .mem_ready(mem_ready));

    typedef struct packed {logic [24:0] addr; logic [7:0] data;} ent_t;
    typedef struct {string nm; logic [31:0] act; logic [31:0] exp;} lit_t;

    int n_tests = 0, n_fail = 0;
    lit_t lits[512];
    int   n_lit = 0, lit_rd = 0;

    ent_t        exp_q[$];
    bit          inflight_w = 0, inflight_r = 0, m_rd_busy = 0, m_dl_prev = 0, m_armed = 0;
    bit          model_live = 0;
    logic [24:0] m_rd_addr = '0;
    logic        e_wait = 0, e_rd_valid = 0, e_load_done = 0, e_overflow = 0;
    logic [7:0]  e_rd_data = '0;
    logic [24:0] e_load_size = '0;
    int          pre_q_size = 0;

    bit          stuck = 0;
    int          lat = 3;
    int          busy = 0;
    logic        we_prev = 0, rd_prev = 0;
    int          wr_count = 0, rd_count = 0, rv_count = 0, rd_wr_snap = 0;
    logic [27:0] wr_log [256];
    logic [7:0]  din_log[256];
    logic [27:0] b_log  [256];

    function automatic logic [7:0] port_byte(input logic [27:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model + port on posedge/negedge; also drains the literal checks posted by the stimulus
    always @(posedge clk or negedge clk) begin
        int   occ;
        bit   rise, ws, rs;
        ent_t ent;
        if (clk) begin
            if (!reset_n) begin
                exp_q.delete();
                inflight_w = 0; inflight_r = 0; m_rd_busy = 0; m_dl_prev = 0; m_armed = 0;
                e_wait = 0; e_rd_valid = 0; e_load_done = 0; e_overflow = 0;
                e_rd_data = '0; e_load_size = '0; pre_q_size = 0;
            end else begin
                occ        = exp_q.size() + int'(inflight_w);
                pre_q_size = exp_q.size();
                rise       = ioctl_download && !m_dl_prev;
                if (rise) begin
                    e_load_done = 0; m_armed = 1;
                end else if (m_armed && !ioctl_download && occ == 0 && !inflight_r) begin
                    e_load_done = 1; m_armed = 0;
                end
                e_overflow = (e_overflow && !rise) || (ioctl_wr && occ == 8);
                if (rise) e_load_size = '0;
                if (ioctl_wr && occ < 8) begin
                    exp_q.push_back({ioctl_addr, ioctl_dout});
                    if (ioctl_addr + 25'd1 > e_load_size) e_load_size = ioctl_addr + 25'd1;
                end
                e_rd_valid = 0;
                if (inflight_w && mem_ready) inflight_w = 0;
                if (inflight_r && mem_ready) begin
                    inflight_r = 0; e_rd_valid = 1; m_rd_busy = 0;
                    e_rd_data = port_byte(BASE_A + {3'b0, m_rd_addr});
                end else if (rd_req && !m_rd_busy) begin
                    m_rd_busy = 1; m_rd_addr = rd_addr;
                end
                e_wait    = (exp_q.size() + int'(inflight_w)) >= 6;
                m_dl_prev = ioctl_download;
            end
            model_live = 1;
        end else begin
            if (model_live) begin
                chk("ioctl_wait", {31'b0, a_wait}, {31'b0, e_wait});
                chk("rd_busy", {31'b0, a_rd_busy}, {31'b0, m_rd_busy});
                chk("rd_valid", {31'b0, a_rd_valid}, {31'b0, e_rd_valid});
                chk("rd_data", {24'b0, a_rd_data}, {24'b0, e_rd_data});
                chk("load_done", {31'b0, a_load_done}, {31'b0, e_load_done});
                chk("load_size", {7'b0, a_load_size}, {7'b0, e_load_size});
                chk("overflow", {31'b0, a_overflow}, {31'b0, e_overflow});
            end
            if (a_rd_valid === 1'b1) rv_count++;
            ws = (a_mem_we === 1'b1) && !we_prev;
            rs = (a_mem_rd === 1'b1) && !rd_prev;
            we_prev = (a_mem_we === 1'b1);
            rd_prev = (a_mem_rd === 1'b1);
            if (busy > 0) busy--;
            if (ws || rs) busy = lat;
            if (ws) begin
                chk("wr_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    ent = exp_q.pop_front();
                    chk("wr_addr", {4'b0, a_mem_addr}, {4'b0, BASE_A + {3'b0, ent.addr}});
                    chk("wr_din", {24'b0, a_mem_din}, {24'b0, ent.data});
                    chk("b_wr_addr", {4'b0, b_mem_addr}, {4'b0, BASE_B + {3'b0, ent.addr}});
                    chk("b_mem_we", {31'b0, b_mem_we}, 32'd1);
                end
                wr_log[wr_count[7:0]]  = a_mem_addr;
                din_log[wr_count[7:0]] = a_mem_din;
                b_log[wr_count[7:0]]   = b_mem_addr;
                wr_count++;
                inflight_w = 1;
            end
            if (rs) begin
                chk("rd_pending", {31'b0, m_rd_busy}, 32'd1);
                chk("rd_after_writes", pre_q_size, 0);
                chk("rd_mem_addr", {4'b0, a_mem_addr}, {4'b0, BASE_A + {3'b0, m_rd_addr}});
                mem_dout   = port_byte(a_mem_addr);
                rd_wr_snap = wr_count;
                rd_count++;
                inflight_r = 1;
            end
            mem_ready = !stuck && busy == 0;
            while (lit_rd < n_lit) begin
                chk(lits[lit_rd].nm, lits[lit_rd].act, lits[lit_rd].exp);
                lit_rd++;
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lits[n_lit] = '{nm, act, exp};
        n_lit++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic push_fc(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (a_wait && n < 200) begin tick(); n++; end
        lit("ioctl_wait_timeout", {31'b0, n < 200}, 32'd1);
        push(a, d);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || inflight_w || inflight_r || m_rd_busy) && n < 500) begin
            tick(); n++;
        end
        lit(nm, {31'b0, n < 500}, 32'd1);
        tick(); tick();
    endtask

    initial begin
        int base, rbase, vbase, n;
        logic [27:0] exp_b [4];
        exp_b[0] = 28'hFFFFFFE; exp_b[1] = 28'hFFFFFFF; exp_b[2] = 28'h0000000; exp_b[3] = 28'h0000001;

        repeat (3) tick();
        lit("rst_mem_we", {31'b0, a_mem_we}, 32'd0);
        lit("rst_mem_rd", {31'b0, a_mem_rd}, 32'd0);
        lit("rst_wait", {31'b0, a_wait}, 32'd0);
        lit("rst_load_size", {7'b0, a_load_size}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: 16-byte download, 3-cycle busy port
        lat = 3; base = wr_count;
        ioctl_download = 1'b1; tick();
        for (int i = 0; i < 16; i++) push_fc(25'(i), 8'hA0 + 8'(i));
        ioctl_download = 1'b0;
        wait_idle("t1_timeout");
        lit("t1_write_count", wr_count - base, 32'd16);
        for (int i = 0; i < 16; i++) lit("t1_mem_addr", {4'b0, wr_log[base+i]}, i);
        lit("t1_last_din", {24'b0, din_log[base+15]}, 32'hAF);
        lit("t1_load_size", {7'b0, a_load_size}, 32'd16);
        lit("t1_load_done", {31'b0, a_load_done}, 32'd1);
        lit("t1_overflow", {31'b0, a_overflow}, 32'd0);

        // 2: ready stuck low, 12 back-to-back bytes
        ioctl_download = 1'b1; tick();
        stuck = 1; tick(); tick();
        base = wr_count;
        for (int i = 0; i < 12; i++) begin
            push(25'h100 + 25'(i), 8'(i));
            if (i == 6) lit("t2_wait_by_7th", {31'b0, a_wait}, 32'd1);
        end
        lit("t2_overflow", {31'b0, a_overflow}, 32'd1);
        stuck = 0; ioctl_download = 1'b0;
        wait_idle("t2_timeout");
        lit("t2_write_count", wr_count - base, 32'd8);
        lit("t2_load_size", {7'b0, a_load_size}, 32'h108);
        lit("t2_load_done", {31'b0, a_load_done}, 32'd1);

        // 3: wrap of the offset base
        ioctl_download = 1'b1; tick();
        base = wr_count;
        for (int i = 0; i < 4; i++) push_fc(25'(i), 8'h30 + 8'(i));
        ioctl_download = 1'b0;
        wait_idle("t3_timeout");
        for (int i = 0; i < 4; i++) lit("t3_wrap_addr", {4'b0, b_log[base+i]}, {4'b0, exp_b[i]});
        lit("t3_overflow_cleared", {31'b0, a_overflow}, 32'd0);
        lit("t3_load_size", {7'b0, a_load_size}, 32'd4);

        // 4: read requested with 4 writes queued, second request while busy
        ioctl_download = 1'b1; tick();
        base = wr_count; rbase = rd_count; vbase = rv_count;
        for (int i = 0; i < 4; i++) push(25'h20 + 25'(i), 8'h50 + 8'(i));
        rd_req = 1'b1; rd_addr = 25'd5; tick();
        rd_req = 1'b0; tick();
        rd_req = 1'b1; rd_addr = 25'd9; tick();
        rd_req = 1'b0;
        wait_idle("t4_timeout");
        ioctl_download = 1'b0; tick();
        lit("t4_read_count", rd_count - rbase, 32'd1);
        lit("t4_writes_before_read", rd_wr_snap - base, 32'd4);
        lit("t4_rd_valid_pulses", rv_count - vbase, 32'd1);
        lit("t4_rd_data", {24'b0, a_rd_data}, 32'h39);

        // 5: cache-hit port, back-to-back reads
        lat = 1; rbase = rd_count; vbase = rv_count;
        for (int k = 0; k < 3; k++) begin
            rd_req = 1'b1; rd_addr = 25'h40 + 25'(k); tick();
            rd_req = 1'b0;
            n = 0;
            while (!a_rd_valid && n < 50) begin tick(); n++; end
            lit("t5_rd_valid_timeout", {31'b0, n < 50}, 32'd1);
        end
        tick();
        lit("t5_read_count", rd_count - rbase, 32'd3);
        lit("t5_rd_valid_pulses", rv_count - vbase, 32'd3);
        lit("t5_last_rd_data", {24'b0, a_rd_data}, 32'h7E);

        // 6: reset while a write strobe is high
        lat = 6;
        ioctl_download = 1'b1; tick();
        for (int i = 0; i < 8; i++) push(25'h300 + 25'(i), 8'hC0 + 8'(i));
        n = 0;
        while (!a_mem_we && n < 100) begin tick(); n++; end
        lit("t6_strobe_timeout", {31'b0, n < 100}, 32'd1);
        reset_n = 1'b0; ioctl_download = 1'b0;
        tick();
        lit("t6_mem_we", {31'b0, a_mem_we}, 32'd0);
        lit("t6_wait", {31'b0, a_wait}, 32'd0);
        lit("t6_load_done", {31'b0, a_load_done}, 32'd0);
        lit("t6_load_size", {7'b0, a_load_size}, 32'd0);
        reset_n = 1'b1;
        base = wr_count;
        repeat (4) tick();
        lit("t6_fifo_empty", wr_count - base, 32'd0);
        ioctl_download = 1'b1; tick();
        for (int i = 0; i < 3; i++) push_fc(25'h10 + 25'(i), 8'h70 + 8'(i));
        ioctl_download = 1'b0;
        wait_idle("t6_timeout");
        lit("t6_restart_writes", wr_count - base, 32'd3);
        lit("t6_restart_size", {7'b0, a_load_size}, 32'h13);
        lit("t6_restart_done", {31'b0, a_load_done}, 32'd1);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
